// File: rtl/soc_system_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : soc_system_pkg
//  Description : Shared definitions for the soc_system button PIO: Avalon-MM
//                register word offsets and a counter-width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package soc_system_pkg;

    // Avalon-MM register word offsets
    localparam logic [1:0] C_REG_DATA      = 2'd0;  // debounced button levels
    localparam logic [1:0] C_REG_DIRECTION = 2'd1;  // input-only PIO, reads zero
    localparam logic [1:0] C_REG_IRQMASK   = 2'd2;  // per-bit interrupt enable
    localparam logic [1:0] C_REG_EDGECAP   = 2'd3;  // press capture, write-1-to-clear

    // ceil(log2(value)) with a floor of one bit so a counter always exists
    function automatic int clog2_min1(input int value);
        int width;
        width = $clog2(value);
        return (width < 1) ? 1 : width;
    endfunction

endpackage
`default_nettype wire

// File: rtl/soc_system_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : soc_system_debounce
//  Description : One button bit: 2-flop synchronizer followed by a stability
//                counter. The output only follows the synced pin after it has
//                differed from the accepted level for DEBOUNCE_CYCLES cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module soc_system_debounce
    import soc_system_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic pin,
    output logic stable
);

    localparam int                CNT_W      = clog2_min1(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]  C_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_meta;
    logic             r_sync;
    logic             r_stable;
    logic [CNT_W-1:0] r_count;

    // Two-flop synchronizer; idles high (button released) out of reset
    always_ff @(posedge clk) begin
        if (reset) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= pin;
            r_sync <= r_meta;
        end
    end

    // Stability counter: any agreement restarts it, acceptance clears it, so it never wraps
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count  <= '0;
            r_stable <= 1'b1;
        end else if (r_sync == r_stable) begin
            r_count  <= '0;
        end else if (r_count == C_CNT_LAST) begin
            r_stable <= r_sync;
            r_count  <= '0;
        end else begin
            r_count  <= r_count + CNT_W'(1);
        end
    end

    assign stable = r_stable;

endmodule
`default_nettype wire

// File: rtl/soc_system_button_in_pio.sv
`default_nettype none
// ============================================================================
//  Module      : soc_system_button_in_pio
//  Description : Avalon-MM input PIO for push buttons (active-low). Debounces
//                each pin, captures presses (falling edges of the debounced
//                level) and raises a level interrupt for unmasked captures.
//  Revision    : 1.0 - initial release
// ============================================================================
module soc_system_button_in_pio
    import soc_system_pkg::*;
#(
    parameter int WIDTH           = 3,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    logic [WIDTH-1:0] w_stable;
    logic [WIDTH-1:0] r_stable_prev;
    logic [WIDTH-1:0] r_irqmask;
    logic [WIDTH-1:0] r_edgecapture;
    logic [WIDTH-1:0] w_press;
    logic [WIDTH-1:0] w_clear;
    logic             w_wr_en;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_debounce
            soc_system_debounce #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_debounce (
                .clk    (clk),
                .reset  (reset),
                .pin    (in_port[gi]),
                .stable (w_stable[gi])
            );
        end
    endgenerate

    // Upper write-data bits have no register behind them
    generate
        if (WIDTH < 32) begin : g_unused_wdata
            logic w_unused_wdata;
            assign w_unused_wdata = ^writedata[31:WIDTH];
        end
    endgenerate

    assign w_wr_en = chipselect & ~write_n;
    // A press is the debounced level going 1 -> 0
    assign w_press = r_stable_prev & ~w_stable;
    assign w_clear = (w_wr_en && (address == C_REG_EDGECAP)) ? writedata[WIDTH-1:0] : '0;

    // Delayed copy of the debounced levels; reset matches the forced all-ones level so reset never looks like a press
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stable_prev <= '1;
        end else begin
            r_stable_prev <= w_stable;
        end
    end

    // Interrupt mask register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_irqmask <= '0;
        end else if (w_wr_en && (address == C_REG_IRQMASK)) begin
            r_irqmask <= writedata[WIDTH-1:0];
        end
    end

    // Edge capture: write-1-to-clear, a new press on the same edge wins
    always_ff @(posedge clk) begin
        if (reset) begin
            r_edgecapture <= '0;
        end else begin
            r_edgecapture <= (r_edgecapture & ~w_clear) | w_press;
        end
    end

    // Zero-wait-state read mux, independent of chipselect
    always_comb begin
        readdata = '0;
        case (address)
            C_REG_DATA:      readdata = 32'(w_stable);
            C_REG_DIRECTION: readdata = '0;
            C_REG_IRQMASK:   readdata = 32'(r_irqmask);
            C_REG_EDGECAP:   readdata = 32'(r_edgecapture);
            default:         readdata = '0;
        endcase
    end

    assign irq = |(r_edgecapture & r_irqmask);

endmodule
`default_nettype wire

// File: tb/tb_soc_system_button_in_pio.sv
`default_nettype none
// ============================================================================
//  Module      : tb_soc_system_button_in_pio
//  Description : Self-checking bench for soc_system_button_in_pio with
//                WIDTH = 3, DEBOUNCE_CYCLES = 4.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_soc_system_button_in_pio;
    import soc_system_pkg::*;

    localparam int WIDTH           = 3;
    localparam int DEBOUNCE_CYCLES = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic [1:0]       address;
    logic             chipselect;
    logic             write_n;
    logic [31:0]      writedata;
    logic [31:0]      readdata;
    logic [WIDTH-1:0] in_port;
    logic             irq;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0]  addr;
        logic [31:0] data;
        logic        irq;
    } exp_t;

    exp_t  sb_q[$];
    string name_q[$];

    typedef struct {
        logic [WIDTH-1:0] pin;
        logic [31:0]      exp_data;
        logic [31:0]      exp_edge;
        logic             exp_irq;
    } vec_t;

    vec_t vecs[7];

    soc_system_button_in_pio #(
        .WIDTH           (WIDTH),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .in_port    (in_port),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    // One clock, leaving us 1 ns past the rising edge
    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic compare_front();
        exp_t  e;
        string nm;
        e  = sb_q.pop_front();
        nm = name_q.pop_front();
        checks++;
        if (readdata !== e.data || irq !== e.irq) begin
            errors++;
            $display("FAIL %s: addr=%0d readdata=0x%0h irq=%b, required readdata=0x%0h irq=%b",
                     nm, e.addr, readdata, irq, e.data, e.irq);
        end
    endtask

    // Queue the expectation, select the register, then compare once the mux settles
    task automatic expect_read(input logic [1:0] a, input logic [31:0] d,
                               input logic i, input string nm);
        exp_t e;
        e.addr = a;
        e.data = d;
        e.irq  = i;
        sb_q.push_back(e);
        name_q.push_back(nm);
        address = a;
        #1;
        compare_front();
    endtask

    // Single-cycle Avalon write; the register updates on the next rising edge
    task automatic write_reg(input logic [1:0] a, input logic [31:0] d);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = a;
        writedata  = d;
        step(1);
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Bit-0 press, one entry per cycle after the pin falls
        vecs[0] = '{pin: 3'b110, exp_data: 32'h7, exp_edge: 32'h0, exp_irq: 1'b0};
        vecs[1] = '{pin: 3'b110, exp_data: 32'h7, exp_edge: 32'h0, exp_irq: 1'b0};
        vecs[2] = '{pin: 3'b110, exp_data: 32'h7, exp_edge: 32'h0, exp_irq: 1'b0};
        vecs[3] = '{pin: 3'b110, exp_data: 32'h7, exp_edge: 32'h0, exp_irq: 1'b0};
        vecs[4] = '{pin: 3'b110, exp_data: 32'h7, exp_edge: 32'h0, exp_irq: 1'b0};
        vecs[5] = '{pin: 3'b110, exp_data: 32'h6, exp_edge: 32'h0, exp_irq: 1'b0};
        vecs[6] = '{pin: 3'b110, exp_data: 32'h6, exp_edge: 32'h1, exp_irq: 1'b0};

        reset      = 1'b1;
        address    = C_REG_DATA;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        in_port    = 3'b111;
        step(3);
        reset = 1'b0;

        // Reset state
        expect_read(C_REG_DATA,      32'h7, 1'b0, "reset_data");
        expect_read(C_REG_DIRECTION, 32'h0, 1'b0, "reset_dir");
        expect_read(C_REG_IRQMASK,   32'h0, 1'b0, "reset_mask");
        expect_read(C_REG_EDGECAP,   32'h0, 1'b0, "reset_edge");

        // Bit-0 press: accepted 6 cycles after the pin, captured on the 7th
        for (int i = 0; i < 7; i++) begin
            in_port = vecs[i].pin;
            step(1);
            expect_read(C_REG_DATA,    vecs[i].exp_data, vecs[i].exp_irq, $sformatf("press0_data_c%0d", i + 1));
            expect_read(C_REG_EDGECAP, vecs[i].exp_edge, vecs[i].exp_irq, $sformatf("press0_edge_c%0d", i + 1));
        end

        // Unmask -> irq; clear -> irq drops
        write_reg(C_REG_IRQMASK, 32'h1);
        expect_read(C_REG_IRQMASK, 32'h1, 1'b1, "mask_irq_on");
        write_reg(C_REG_EDGECAP, 32'h1);
        expect_read(C_REG_EDGECAP, 32'h0, 1'b0, "clear_irq_off");

        // Release bit 0: rising edge is not captured
        in_port = 3'b111;
        step(8);
        expect_read(C_REG_DATA,    32'h7, 1'b0, "release0_data");
        expect_read(C_REG_EDGECAP, 32'h0, 1'b0, "release0_edge");

        // Bit-1 glitch of 3 cycles is rejected
        in_port = 3'b101;
        step(3);
        in_port = 3'b111;
        for (int i = 0; i < 8; i++) begin
            step(1);
            expect_read(C_REG_DATA, 32'h7, 1'b0, $sformatf("glitch1_data_c%0d", i + 4));
        end
        expect_read(C_REG_EDGECAP, 32'h0, 1'b0, "glitch1_edge");

        // Bit-2 press whose capture coincides with a clear of bit 2: set wins
        in_port = 3'b011;
        step(6);
        expect_read(C_REG_DATA,    32'h3, 1'b0, "press2_data");
        expect_read(C_REG_EDGECAP, 32'h0, 1'b0, "press2_edge_before");
        write_reg(C_REG_EDGECAP, 32'h4);
        expect_read(C_REG_EDGECAP, 32'h4, 1'b0, "press2_set_wins");
        write_reg(C_REG_EDGECAP, 32'h4);
        expect_read(C_REG_EDGECAP, 32'h0, 1'b0, "press2_cleared");
        in_port = 3'b111;
        step(8);
        expect_read(C_REG_DATA, 32'h7, 1'b0, "release2_data");

        // Reset two cycles into a bit-0 debounce with the pin held low
        in_port = 3'b110;
        step(2);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        expect_read(C_REG_DATA,    32'h7, 1'b0, "rst_mid_data");
        expect_read(C_REG_EDGECAP, 32'h0, 1'b0, "rst_mid_edge");
        expect_read(C_REG_IRQMASK, 32'h0, 1'b0, "rst_mid_mask");
        step(5);
        expect_read(C_REG_DATA,    32'h7, 1'b0, "rst_press_c5");
        step(1);
        expect_read(C_REG_DATA,    32'h6, 1'b0, "rst_press_c6");
        expect_read(C_REG_EDGECAP, 32'h0, 1'b0, "rst_edge_c6");
        step(1);
        expect_read(C_REG_EDGECAP, 32'h1, 1'b0, "rst_edge_c7");

        // Unmasked capture on bit 0 drives irq
        write_reg(C_REG_IRQMASK, 32'h7);
        expect_read(C_REG_IRQMASK, 32'h7, 1'b1, "final_mask_irq");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/soc_system_button_in_pio.md
SOC_SYSTEM_BUTTON_IN_PIO -- requirements
Module: soc_system_button_in_pio

Interface
REQ-001 The block SHALL have parameter WIDTH, default 3: number of button inputs.
REQ-002 The block SHALL have parameter DEBOUNCE_CYCLES, default 50000 (1 ms at 50 MHz), legal range 1..2^20: cycles an input must be stable before acceptance.
REQ-003 Port: clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port: reset  input  1  reset, synchronous and active-high.
REQ-005 Port: address  input  2  Avalon-MM register word select.
REQ-006 Port: chipselect  input  1  Avalon-MM slave select.
REQ-007 Port: write_n  input  1  Avalon-MM write strobe, active-low.
REQ-008 Port: writedata  input  32  Avalon-MM write data.
REQ-009 Port: readdata  output  32  Avalon-MM read data, zero read-wait-state.
REQ-010 Port: in_port  input  WIDTH  asynchronous button pins, idle high (pressed = 0).
REQ-011 Port: irq  output  1  level interrupt, active-high.

Function
REQ-012 Each in_port bit SHALL pass through a 2-flop synchronizer; sync output changes 2 cycles after the pin.
REQ-013 Per bit, a debounce counter SHALL clear whenever synced == stable, and increment each cycle synced != stable.
REQ-014 When synced != stable and counter == DEBOUNCE_CYCLES-1, stable SHALL take synced and counter SHALL clear on that edge; total pin-to-stable latency = 2 + DEBOUNCE_CYCLES cycles.
REQ-015 A pin pulse shorter than DEBOUNCE_CYCLES synced cycles SHALL leave stable unchanged; counter SHALL never exceed DEBOUNCE_CYCLES-1 (no wrap).
REQ-016 A falling edge on stable (1 -> 0, press) SHALL set the matching edgecapture bit one cycle after stable changes; rising edges SHALL NOT set it.
REQ-017 Register map, read: addr 0 = stable; addr 1 = 0; addr 2 = irqmask; addr 3 = edgecapture; all zero-extended to 32 bits.
REQ-018 readdata SHALL be combinational from address and registers, independent of chipselect.
REQ-019 Write (chipselect & ~write_n) to addr 2 SHALL load irqmask <= writedata[WIDTH-1:0]; writes to addr 0/1 SHALL be ignored.
REQ-020 Write to addr 3 SHALL clear each edgecapture bit whose writedata bit is 1 (write-1-to-clear); 0 bits unaffected.
REQ-021 Simultaneous new edge and clear on the same bit SHALL leave the bit set (set wins).
REQ-022 irq SHALL equal OR-reduce(edgecapture & irqmask), combinational from registers; no extra latency.

Reset
REQ-023 On reset high at a clk edge: synchronizer flops and stable SHALL go to all-ones, counters to 0, irqmask to 0, edgecapture to 0; hence irq = 0 and addr-0 readdata = 2^WIDTH-1.
REQ-024 Reset mid-debounce SHALL discard the pending count; no edge SHALL be captured for stable being forced to all-ones.
REQ-025 If a pin is low when reset releases, the press SHALL be accepted after 2 + DEBOUNCE_CYCLES cycles and captured as a falling edge.

Structure
REQ-026 Register offsets (0..3) SHALL be defined as constants in the shared soc_system package/include, not literals.
REQ-027 Synchronizer + counter + stable flop per bit SHALL be one sub-module, soc_system_debounce, instantiated WIDTH times via generate.
REQ-028 Counter width SHALL be clog2(DEBOUNCE_CYCLES), minimum 1.

Verification (DEBOUNCE_CYCLES = 4, WIDTH = 3)
REQ-029 Reset, in_port=3'b111 -> readdata addr0 = 0x7, addr2 = 0, addr3 = 0, irq = 0.
REQ-030 in_port[0] 1->0 held -> addr0 = 0x6 exactly 6 cycles later, edgecapture = 0x1 at cycle 7, irq stays 0 (mask 0).
REQ-031 Write addr2 = 0x1 after REQ-030 -> irq = 1 next cycle; write addr3 = 0x1 -> edgecapture = 0, irq = 0 next cycle.
REQ-032 in_port[1] low for 3 cycles then high -> addr0 stays 0x7, edgecapture unchanged.
REQ-033 Edge on bit 2 lands same cycle as write addr3 = 0x4 -> edgecapture bit 2 remains 1.
REQ-034 Reset asserted 2 cycles into a bit-0 press debounce, pin held low -> after release, addr0 = 0x6 exactly 6 cycles later, edgecapture bit0 = 1 one cycle after.
